axis_to_bus: RTL

AXIS_TO_BUS -- requirements
Module: axis_to_bus

---
 rtl/axis_to_bus_pkg.sv | 13 +
 rtl/axis_skid_buffer.sv | 76 +++++++
 rtl/axis_to_bus.sv | 67 ++++++
 3 files changed

// File: rtl/axis_to_bus_pkg.sv
// Shared types and default widths for the stream-to-bus adapter.
package axis_to_bus_pkg;

  localparam int DEFAULT_DOUT_WIDTH = 16;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry in-order buffer between the slave stream and the output register.
// slot0 always holds the oldest word; ready depends only on registered state.
module axis_skid_buffer
  import axis_to_bus_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DOUT_WIDTH
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             run,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pop_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  occ_state_t       state;
  occ_state_t       state_next;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             push;
  logic             pop;

  assign push = in_valid && in_ready;
  assign pop  = pop_en && out_valid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = TWO;
        else if (pop && !push) state_next = EMPTY;
      end
      TWO:     if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = run && (state != TWO);
    out_valid = (state != EMPTY);
    out_data  = slot0;
  end

  // A pop from TWO shifts slot1 forward; a push lands behind whatever survives the pop.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (pop) begin
      if (state == TWO) begin
        slot0 <= slot1;
      end else if (push) begin
        slot0 <= in_data;
      end
    end else if (push) begin
      if (state == EMPTY) begin
        slot0 <= in_data;
      end else begin
        slot1 <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_to_bus.sv
// AXI-stream to registered parallel bus with update strobe and counter.
// Optional macro AXIS_TO_BUS_CHANGE_ONLY_EN: strobe/count only when the value changes.
module axis_to_bus
  import axis_to_bus_pkg::*;
#(
  parameter int DOUT_WIDTH = DEFAULT_DOUT_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DOUT_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  bus_en,
  output logic [DOUT_WIDTH-1:0] data_out,
  output logic                  data_strobe,
  output logic [CNT_WIDTH-1:0]  update_count
);

  logic                  run_reg;
  logic                  buf_valid;
  logic [DOUT_WIDTH-1:0] buf_data;
  logic                  pop;
  logic                  strobe_next;

  axis_skid_buffer #(
    .WIDTH (DOUT_WIDTH)
  ) u_buffer (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .run       (run_reg),
    .in_data   (s_axis_tdata),
    .in_valid  (s_axis_tvalid),
    .in_ready  (s_axis_tready),
    .pop_en    (bus_en),
    .out_data  (buf_data),
    .out_valid (buf_valid)
  );

  assign pop = bus_en && buf_valid;

`ifdef AXIS_TO_BUS_CHANGE_ONLY_EN
  assign strobe_next = pop && (buf_data != data_out);
`else
  assign strobe_next = pop;
`endif

  // run_reg holds tready low for the first cycle after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_reg      <= 1'b0;
      data_out     <= '0;
      data_strobe  <= 1'b0;
      update_count <= '0;
    end else begin
      run_reg     <= 1'b1;
      data_strobe <= strobe_next;
      if (pop) begin
        data_out <= buf_data;
      end
      if (strobe_next) begin
        update_count <= update_count + 1'b1;
      end
    end
  end

endmodule
